// File: rtl/div_request_sequencer.sv
// Request/response sequencer wrapped around a 32-cycle iterative unsigned divider.
// Divide-by-zero and dividend < divisor are answered locally. Every other request
// starts the divider and waits for its completion pulse. The result is then held
// until the downstream handshake.
module div_request_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder,
  output logic              o_divByZero,
  output logic              o_divStart,
  output logic [DATA_W-1:0] o_divDividend,
  output logic [DATA_W-1:0] o_divDivisor,
  input  logic [DATA_W-1:0] i_divQuotient,
  input  logic [DATA_W-1:0] i_divRemainder,
  input  logic              i_divFinish
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              valid_q;
  logic              start_q;

  // Next-state and result/operand capture; everything holds unless a transition updates it.
  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i_divisor == {DATA_W{1'b0}}) begin
            quot_d  = {DATA_W{1'b1}};
            rem_d   = i_dividend;
            dbz_d   = 1'b1;
            state_d = HOLD;
          end else if (i_dividend < i_divisor) begin
            quot_d  = {DATA_W{1'b0}};
            rem_d   = i_dividend;
            dbz_d   = 1'b0;
            state_d = HOLD;
          end else begin
            dvd_d   = i_dividend;
            dvs_d   = i_divisor;
            state_d = START;
          end
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Completion is only honoured here; stray pulses elsewhere are ignored.
        if (i_divFinish) begin
          quot_d  = i_divQuotient;
          rem_d   = i_divRemainder;
          dbz_d   = 1'b0;
          state_d = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (i_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, result and operand registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      quot_q  <= {DATA_W{1'b0}};
      rem_q   <= {DATA_W{1'b0}};
      dbz_q   <= 1'b0;
      dvd_q   <= {DATA_W{1'b0}};
      dvs_q   <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      valid_q <= (state_d == HOLD);
      start_q <= (state_d == START);
    end
  end

  // Ready is tied to reset directly so it reads 1 in the first cycle after release.
  assign o_ready       = (state_q == IDLE) && i_arst_n;
  assign o_valid       = valid_q;
  assign o_divStart    = start_q;
  assign o_quotient    = quot_q;
  assign o_remainder   = rem_q;
  assign o_divByZero   = dbz_q;
  assign o_divDividend = dvd_q;
  assign o_divDivisor  = dvs_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// Self-checking bench for div_request_sequencer, with a behavioural 32-cycle divider.
module tb_div_request_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, o_valid, i_ready;
  logic [31:0] i_dividend, i_divisor, o_quotient, o_remainder;
  logic        o_divByZero, o_divStart;
  logic [31:0] o_divDividend, o_divDivisor, i_divQuotient, i_divRemainder;
  logic        i_divFinish;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_request_sequencer #(.DATA_W(32)) dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_dividend(i_dividend), .i_divisor(i_divisor),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_quotient(o_quotient), .o_remainder(o_remainder), .o_divByZero(o_divByZero),
    .o_divStart(o_divStart), .o_divDividend(o_divDividend), .o_divDivisor(o_divDivisor),
    .i_divQuotient(i_divQuotient), .i_divRemainder(i_divRemainder), .i_divFinish(i_divFinish)
  );

  // Divider model: samples start, pulses finish 32 cycles later, never reset.
  int unsigned cnt = 0;
  logic [31:0] mq = 32'd0;
  logic [31:0] mr = 32'd0;
  logic        spur = 1'b0;

  always @(posedge clk) begin
    if (o_divStart) begin
      cnt <= 32;
      if (o_divDivisor != 32'd0) begin
        mq <= o_divDividend / o_divDivisor;
        mr <= o_divDividend % o_divDivisor;
      end else begin
        mq <= 32'hFFFF_FFFF;
        mr <= o_divDividend;
      end
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  assign i_divFinish    = (cnt == 1) || spur;
  assign i_divQuotient  = spur ? 32'hDEAD_BEEF : mq;
  assign i_divRemainder = spur ? 32'h0BAD_F00D : mr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One request through to handshake; hold = cycles i_ready stays low in HOLD.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output int starts);
    int guard;
    guard = 0;
    while (!o_ready && guard < 200) begin
      step();
      guard++;
    end
    chk("ready_before_req", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_dividend = a; i_divisor = b;
    step();
    i_valid = 1'b0; i_dividend = $urandom; i_divisor = $urandom;
    lat = 1; starts = 0;
    while (!o_valid && lat < 100) begin
      if (o_divStart) starts++;
      step();
      lat++;
    end
    q = o_quotient; r = o_remainder; dz = o_divByZero;
    for (int k = 0; k < hold; k++) begin
      step();
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_ready", 32'(o_ready), 32'd0);
      chk("hold_q", o_quotient, q);
      chk("hold_r", o_remainder, r);
      chk("hold_dz", 32'(o_divByZero), 32'(dz));
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk("valid_after_hs", 32'(o_valid), 32'd0);
    chk("ready_after_hs", 32'(o_ready), 32'd1);
  endtask

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        dz;
    int          lat, starts;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] q, r, a, b, eq, er, sq;
  logic        dz, edz;
  int          lat, st, elat, cnt_v;

  initial begin
    tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1};
    tbl[1] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0};
    tbl[2] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1, 0};
    tbl[3] = '{32'd10, 32'd10, 32'd1, 32'd0, 1'b0, 34, 1};
    tbl[4] = '{32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 34, 1};
    tbl[5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 0};
    tbl[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1, 0};
    tbl[7] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 1};

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_dividend = 32'd0; i_divisor = 32'd0;
    #1;
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_start", 32'(o_divStart), 32'd0);
    chk("rst_q", o_quotient, 32'd0);
    chk("rst_r", o_remainder, 32'd0);
    chk("rst_dz", 32'(o_divByZero), 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 32'(o_ready), 32'd1);

    // Directed table, with varying back-pressure.
    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].a, tbl[i].b, (i % 3) * 5, q, r, dz, lat, st);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_dz", i), 32'(dz), 32'(tbl[i].dz));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_starts", i), 32'(st), 32'(tbl[i].starts));
    end

    // Divider operands persist across a fast-path request.
    run_req(32'd3, 32'd10, 0, q, r, dz, lat, st);
    chk("div_dvd_held", o_divDividend, 32'hFFFF_FFFF);
    chk("div_dvs_held", o_divDivisor, 32'd1);

    // Stray finish while idle.
    sq = o_quotient;
    spur = 1'b1; step(); spur = 1'b0;
    chk("spur_idle_valid", 32'(o_valid), 32'd0);
    chk("spur_idle_ready", 32'(o_ready), 32'd1);
    chk("spur_idle_q", o_quotient, sq);

    // Stray finish during START, then during HOLD.
    i_valid = 1'b1; i_dividend = 32'd100; i_divisor = 32'd7;
    step();
    i_valid = 1'b0;
    chk("start_pulse", 32'(o_divStart), 32'd1);
    spur = 1'b1; step(); spur = 1'b0;
    chk("spur_start_valid", 32'(o_valid), 32'd0);
    chk("start_one_cycle", 32'(o_divStart), 32'd0);
    lat = 2;
    while (!o_valid && lat < 100) begin step(); lat++; end
    chk("spur_start_lat", 32'(lat), 32'd34);
    chk("spur_start_q", o_quotient, 32'd14);
    spur = 1'b1; step(); spur = 1'b0;
    chk("spur_hold_q", o_quotient, 32'd14);
    chk("spur_hold_r", o_remainder, 32'd2);
    chk("spur_hold_valid", 32'(o_valid), 32'd1);
    i_ready = 1'b1; step(); i_ready = 1'b0;
    chk("spur_hs_ready", 32'(o_ready), 32'd1);

    // Reset in the middle of WAIT.
    i_valid = 1'b1; i_dividend = 32'd50; i_divisor = 32'd5;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(o_ready), 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_q", o_quotient, 32'd0);
    chk("midrst_r", o_remainder, 32'd0);
    chk("midrst_dvd", o_divDividend, 32'd0);
    chk("midrst_dvs", o_divDivisor, 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 32'(o_ready), 32'd1);
    cnt_v = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_valid || o_divStart) cnt_v++;
    end
    chk("aborted_no_output", 32'(cnt_v), 32'd0);
    run_req(32'd1000, 32'd3, 2, q, r, dz, lat, st);
    chk("post_rst_q", q, 32'd333);
    chk("post_rst_r", r, 32'd1);

    // Random requests against a plain-arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = 32'd0; end
        1: begin b = $urandom_range(1, 1000); a = $urandom_range(0, 1200); end
        2: begin a = $urandom; b = $urandom_range(1, 16); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if (b == 32'd0) begin
        eq = 32'hFFFF_FFFF; er = a; edz = 1'b1; elat = 1;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0; elat = (a < b) ? 1 : 34;
      end
      run_req(a, b, $urandom_range(0, 3), q, r, dz, lat, st);
      chk($sformatf("rnd%0d_q", i), q, eq);
      chk($sformatf("rnd%0d_r", i), r, er);
      chk($sformatf("rnd%0d_dz", i), 32'(dz), 32'(edz));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
      chk($sformatf("rnd%0d_starts", i), 32'(st), (elat == 34) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
